vga_scanout: RTL and testbench

- Display-side consumer of the 8192x24 video memory: generates 640x480@60 VGA timing from a 25 MHz pixel clock.
- Addresses the memory's read port and outputs registered RGB plus sync.
- The 128x64 framebuffer is shown 4x-scaled (512x256) in the top-left of the active area; elsewhere is black.
- Read-port clock of the memory is driven from the same clk.

---
 rtl/vga_scanout.sv | 88 ++++++++
 tb/tb_vga_scanout.sv | 78 +++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 VGA timing that shows a 128x64 framebuffer 4x-scaled in the top-left corner.
// Optional macro VGA_BORDER_EN forces a white one-pixel border around the active area.
module vga_scanout #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int IMG_W       = 128,
  parameter int IMG_H       = 64,
  parameter int SCALE_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [12:0] vmem_addr,
  input  logic [23:0] vmem_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [23:0] rgb,
  output logic        frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = 13 - CW;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic act0, hit0, hs0, vs0, fs0, bd0;
  logic hs1, vs1, de1, hit1, fs1, bd1;
  always_comb begin
    act0 = h_cnt < HW'(H_ACTIVE) && v_cnt < VW'(V_ACTIVE);
    hit0 = !rst && act0 && (h_cnt >> SCALE_SHIFT) < HW'(IMG_W) && (v_cnt >> SCALE_SHIFT) < VW'(IMG_H);
    hs0 = !(h_cnt >= HW'(H_ACTIVE + H_FP) && h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs0 = !(v_cnt >= VW'(V_ACTIVE + V_FP) && v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    fs0 = h_cnt == '0 && v_cnt == '0;
    vmem_addr = hit0 ? {RW'(v_cnt >> SCALE_SHIFT), CW'(h_cnt >> SCALE_SHIFT)} : '0;
  end
`ifdef VGA_BORDER_EN
  assign bd0 = act0 && (h_cnt == '0 || h_cnt == HW'(H_ACTIVE - 1) || v_cnt == '0 || v_cnt == VW'(V_ACTIVE - 1));
`else
  assign bd0 = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HW'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= v_cnt == VW'(V_TOTAL - 1) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end
  // stage 1 lines up with the memory read latency, stage 2 is the output register
  always_ff @(posedge clk) begin
    if (rst) begin
      hs1         <= 1'b1;
      vs1         <= 1'b1;
      de1         <= 1'b0;
      hit1        <= 1'b0;
      fs1         <= 1'b0;
      bd1         <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
    end else begin
      hs1         <= hs0;
      vs1         <= vs0;
      de1         <= act0;
      hit1        <= hit0;
      fs1         <= fs0;
      bd1         <= bd0;
      hsync       <= hs1;
      vsync       <= vs1;
      de          <= de1;
      rgb         <= bd1 ? 24'hFFFFFF : hit1 ? vmem_data : '0;
      frame_start <= fs1;
    end
  end
endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: scoreboard bench; a position model queues expected outputs that are checked two clocks later.
module tb_vga_scanout;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] vmem_addr;
  logic [23:0] vmem_data = '0;
  logic        hsync, vsync, de, frame_start;
  logic [23:0] rgb;
  int checks = 0;
  int failures = 0;
  int mx = 0;
  int my = 0;
  logic [27:0] q[$];
  localparam logic [27:0] RSTV = {1'b1, 1'b1, 1'b0, 1'b0, 24'h0};
  vga_scanout dut (
    .clk(clk), .rst(rst), .vmem_addr(vmem_addr), .vmem_data(vmem_data),
    .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start)
  );
  always #20 clk = ~clk;
  // memory holds its own address as data, one-clock read latency
  always @(posedge clk) vmem_data <= {11'd0, vmem_addr};
  function automatic logic [12:0] exp_addr(int h, int v);
    if (h < 512 && v < 256) return 13'((v / 4) * 128 + h / 4);
    return 13'd0;
  endfunction
  function automatic logic [27:0] exp_pix(int h, int v);
    logic a;
    logic [23:0] c;
    a = h < 640 && v < 480;
    c = (a && h < 512 && v < 256) ? {11'd0, exp_addr(h, v)} : 24'h0;
`ifdef VGA_BORDER_EN
    if (a && (h == 0 || h == 639 || v == 0 || v == 479)) c = 24'hFFFFFF;
`endif
    return {!(h >= 656 && h < 752), !(v == 490 || v == 491), a, h == 0 && v == 0, c};
  endfunction
  task automatic check(input logic [27:0] got, input logic [27:0] exp, input string tag);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s at model h=%0d v=%0d got=%h exp=%h", tag, mx, my, got, exp);
    end
  endtask
  task automatic tick();
    logic [27:0] e;
    if (rst) begin
      e = RSTV;
      q.delete();
      q.push_back(RSTV);
      mx = 0;
      my = 0;
    end else begin
      e = q.pop_front();
      q.push_back(exp_pix(mx, my));
      mx++;
      if (mx == 800) begin
        mx = 0;
        my = (my == 524) ? 0 : my + 1;
      end
    end
    @(posedge clk);
    #1;
    check({hsync, vsync, de, frame_start, rgb}, e, "pixel");
    check({15'd0, vmem_addr}, rst ? 28'd0 : {15'd0, exp_addr(mx, my)}, "addr");
    if (!rst && mx == 5 && my == 9) check({15'd0, vmem_addr}, 28'd257, "addr_5_9");
    if (!rst && mx == 511 && my == 39) check({15'd0, vmem_addr}, 28'd1279, "addr_511_39");
  endtask
  initial begin
    repeat (3) tick();
    rst = 1'b0;
    repeat (40 * 800 + 300) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (12 * 800 + 5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
